// File: rtl/bus_pkg.sv
// Shared types and defaults for the serial-bus transmit arbiter.
// Holds the FSM state encoding and the default parameter values.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NREQ_DEF   = 4;
  localparam int DW_DEF     = 4;
  localparam int TO_CYC_DEF = 64;

endpackage

// File: rtl/bus_tx_arbiter_if.sv
// Client/transmitter bundle around bus_tx_arbiter.
// The arbiter uses the slave modport; stimulus or client logic uses the master modport.
interface bus_tx_arbiter_if
  import bus_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF
);

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_date;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [NREQ-1:0]    err;
  logic               busy;
  logic               tx_valid;
  logic [DW-1:0]      tx_date;
  logic               tx_ack;

  modport slave (
    input  req, req_date, tx_ack,
    output gnt, done, err, busy, tx_valid, tx_date
  );

  modport master (
    output req, req_date, tx_ack,
    input  gnt, done, err, busy, tx_valid, tx_date
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
// Returns the winner both one-hot and as an index; all zero when nothing is requested.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] win_o,
  output logic [PW-1:0]   idx_o
);

  localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);

  logic [PW:0] cand;
  logic        found;

  always_comb begin
    win_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      // One extra bit so ptr+i never overflows before the modulo fold.
      cand = {1'b0, ptr_i} + (PW+1)'(i);
      if (cand >= NREQ_W) begin
        cand = cand - NREQ_W;
      end
      if (!found && req_i[cand[PW-1:0]]) begin
        found                 = 1'b1;
        win_o[cand[PW-1:0]]   = 1'b1;
        idx_o                 = cand[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_tx_arbiter.sv
// Round-robin sequencer sharing one nibble transmitter between NREQ requesters.
// Define ACK_TIMEOUT_EN to abort a transfer with an err pulse after TO_CYC ack-less cycles.
module bus_tx_arbiter
  import bus_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int DW     = DW_DEF,
  parameter int TO_CYC = TO_CYC_DEF
) (
  input logic               sclk,
  input logic               rst,
  bus_tx_arbiter_if.slave   bus
);

  localparam int            PW   = $clog2(NREQ);
  localparam logic [PW-1:0] LAST = PW'(NREQ-1);

  state_t          state_q;
  logic [PW-1:0]   ptr_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] done_q;
  logic [NREQ-1:0] err_q;
  logic            tx_valid_q;
  logic [DW-1:0]   tx_date_q;

  logic [NREQ-1:0] win;
  logic [PW-1:0]   win_idx;
  logic [DW-1:0]   nib [NREQ];
  logic            expire;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_nib
    assign nib[gi] = bus.req_date[gi*DW +: DW];
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .win_o (win),
    .idx_o (win_idx)
  );

`ifdef ACK_TIMEOUT_EN
  localparam int            CW       = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TO_CYC-1);

  logic [CW-1:0] cnt_q;

  // Cleared while idle so every SEND starts counting from zero.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
    end else if (state_q == SEND && !bus.tx_ack) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire = (cnt_q == CNT_LAST);
`else
  logic [31:0] unused_to_cyc;
  assign unused_to_cyc = 32'(TO_CYC);
  assign expire        = 1'b0;
`endif

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_date_q  <= '0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      case (state_q)
        IDLE: begin
          if (|bus.req) begin
            gnt_q      <= win;
            tx_date_q  <= nib[win_idx];
            tx_valid_q <= 1'b1;
            ptr_q      <= (win_idx == LAST) ? '0 : win_idx + 1'b1;
            state_q    <= SEND;
          end
        end
        SEND: begin
          // A same-edge ack beats the timeout.
          if (bus.tx_ack) begin
            tx_valid_q <= 1'b0;
            gnt_q      <= '0;
            done_q     <= gnt_q;
            state_q    <= DONE;
          end else if (expire) begin
            tx_valid_q <= 1'b0;
            gnt_q      <= '0;
            err_q      <= gnt_q;
            state_q    <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_date  = tx_date_q;

endmodule

// File: tb/tb_bus_tx_arbiter.sv
// Bench for bus_tx_arbiter: directed vector table, hand-written corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_bus_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int TO = 8;
`ifdef ACK_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic sclk = 1'b0;
  logic rst  = 1'b1;
  always #5 sclk = ~sclk;

  bus_tx_arbiter_if #(.NREQ(N), .DW(W)) bus ();

  bus_tx_arbiter #(.NREQ(N), .DW(W), .TO_CYC(TO)) dut (
    .sclk (sclk),
    .rst  (rst),
    .bus  (bus.slave)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic [N*W-1:0] date;
    logic         ack;
    logic [N-1:0] gnt;
    logic [N-1:0] done;
    logic         vld;
    logic [W-1:0] txd;
    logic         busy;
  } vec_t;

  vec_t tv[$];

  function automatic void addv(logic r, logic [N-1:0] q, logic [N*W-1:0] d, logic a,
                               logic [N-1:0] g, logic [N-1:0] dn, logic v,
                               logic [W-1:0] t, logic b);
    vec_t x;
    x.rst = r; x.req = q; x.date = d; x.ack = a;
    x.gnt = g; x.done = dn; x.vld = v; x.txd = t; x.busy = b;
    tv.push_back(x);
  endfunction

  task automatic drive(input logic [N-1:0] q, input logic [N*W-1:0] d, input logic a);
    bus.req = q; bus.req_date = d; bus.tx_ack = a;
  endtask

  task automatic step();
    @(negedge sclk);
  endtask

  // Reference model: one transfer at a time, strict rotation, one dead cycle after completion.
  int             m_owner = -1;
  int             m_ptr   = 0;
  int             m_age   = 0;
  bit             m_cool  = 1'b0;
  logic [W-1:0]   m_nib   = '0;
  logic [N-1:0]   m_done  = '0;
  logic [N-1:0]   m_err   = '0;

  function automatic void model_reset();
    m_owner = -1; m_ptr = 0; m_age = 0; m_cool = 1'b0; m_done = '0; m_err = '0;
  endfunction

  function automatic void model_edge(logic [N-1:0] r, logic [N*W-1:0] d, logic a);
    m_done = '0;
    m_err  = '0;
    if (m_owner >= 0) begin
      if (a) begin
        m_done  = N'(1) << m_owner;
        m_owner = -1;
        m_cool  = 1'b1;
      end else begin
        m_age++;
        if (TMO_EN && m_age == TO) begin
          m_err   = N'(1) << m_owner;
          m_owner = -1;
          m_cool  = 1'b1;
        end
      end
    end else if (m_cool) begin
      m_cool = 1'b0;
    end else if (r != '0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (((r >> c) & N'(1)) != '0) begin
          m_owner = c;
          break;
        end
      end
      m_nib = W'(d >> (m_owner * W));
      m_ptr = (m_owner + 1) % N;
      m_age = 0;
    end
  endfunction

  initial begin
    drive('0, '0, 1'b0);
    rst = 1'b1;

    // Reset state while rst is held.
    #8;
    chk("rst gnt",  32'(bus.gnt), 0);
    chk("rst done", 32'(bus.done), 0);
    chk("rst err",  32'(bus.err), 0);
    chk("rst busy", 32'(bus.busy), 0);
    chk("rst vld",  32'(bus.tx_valid), 0);
    chk("rst txd",  32'(bus.tx_date), 0);
    @(negedge sclk);

    // Idle acks do nothing.
    addv(0, 4'b0000, 16'h0000, 1, 0, 0, 0, 0, 0);
    addv(0, 4'b0000, 16'h0000, 1, 0, 0, 0, 0, 0);
    // Single requester 2, nibble A, ack five cycles after grant.
    addv(0, 4'b0100, 16'h0A00, 0, 4'b0100, 0, 1, 4'hA, 1);
    for (int i = 0; i < 4; i++) addv(0, 4'b0100, 16'h0A00, 0, 4'b0100, 0, 1, 4'hA, 1);
    addv(0, 4'b0100, 16'h0A00, 1, 0, 4'b0100, 0, 4'hA, 1);
    addv(0, 4'b0000, 16'h0A00, 0, 0, 0, 0, 4'hA, 0);
    addv(0, 4'b0000, 16'h0A00, 1, 0, 0, 0, 4'hA, 0);
    // Reset to put the pointer back at 0.
    addv(1, 4'b0000, 16'h0000, 0, 0, 0, 0, 4'h0, 0);
    // All four requesting: grant order 0,1,2,3,0, ack on the third SEND edge.
    for (int g = 0; g < 5; g++) begin
      logic [N-1:0] oh;
      logic [W-1:0] nb;
      oh = N'(1) << (g % N);
      nb = W'((g % N) + 1);
      for (int i = 0; i < 3; i++) addv(0, 4'b1111, 16'h4321, 0, oh, 0, 1, nb, 1);
      addv(0, 4'b1111, 16'h4321, 1, 0, oh, 0, nb, 1);
      addv(0, 4'b1111, 16'h4321, 0, 0, 0, 0, nb, 0);
    end

    foreach (tv[i]) begin
      rst = tv[i].rst;
      drive(tv[i].req, tv[i].date, tv[i].ack);
      step();
      chk($sformatf("vec%0d gnt", i),  32'(bus.gnt), 32'(tv[i].gnt));
      chk($sformatf("vec%0d done", i), 32'(bus.done), 32'(tv[i].done));
      chk($sformatf("vec%0d vld", i),  32'(bus.tx_valid), 32'(tv[i].vld));
      chk($sformatf("vec%0d busy", i), 32'(bus.busy), 32'(tv[i].busy));
      chk($sformatf("vec%0d err", i),  32'(bus.err), 0);
      if (tv[i].vld) chk($sformatf("vec%0d txd", i), 32'(bus.tx_date), 32'(tv[i].txd));
    end
    rst = 1'b0;

    // Latched data holds after req_date changes and req drops mid-transfer.
    drive(4'b0010, 16'h00B0, 1'b0); step();
    chk("hold grant", 32'(bus.gnt), 32'(4'b0010));
    drive(4'b0000, 16'h0F0F, 1'b0); step(); step();
    chk("hold txd",  32'(bus.tx_date), 32'hB);
    chk("hold vld",  32'(bus.tx_valid), 1);
    chk("hold gnt",  32'(bus.gnt), 32'(4'b0010));
    drive(4'b0000, 16'h0F0F, 1'b1); step();
    chk("drop done", 32'(bus.done), 32'(4'b0010));
    drive(4'b0000, 16'h0F0F, 1'b0); step();
    chk("drop idle", 32'(bus.busy), 0);

    // Reset during SEND clears outputs without a clock edge.
    drive(4'b0100, 16'h0000, 1'b0); step(); step();
    chk("mid pre vld", 32'(bus.tx_valid), 1);
    rst = 1'b1; #1;
    chk("mid async vld",  32'(bus.tx_valid), 0);
    chk("mid async gnt",  32'(bus.gnt), 0);
    chk("mid async busy", 32'(bus.busy), 0);
    bus.tx_ack = 1'b1;
    step();
    rst = 1'b0;
    drive(4'b0000, 16'h0000, 1'b0); step();
    chk("mid no done", 32'(bus.done), 0);
    drive(4'b0011, 16'h0065, 1'b0); step();
    chk("mid ptr0 gnt", 32'(bus.gnt), 32'(4'b0001));
    chk("mid ptr0 txd", 32'(bus.tx_date), 32'h5);
    drive(4'b0000, 16'h0065, 1'b1); step();
    chk("mid done", 32'(bus.done), 32'(4'b0001));
    drive(4'b0000, 16'h0000, 1'b0); step();

`ifdef ACK_TIMEOUT_EN
    // No ack: err eight cycles after grant.
    drive(4'b0001, 16'h0007, 1'b0); step();
    chk("tmo grant", 32'(bus.gnt), 32'(4'b0001));
    for (int i = 0; i < 7; i++) begin
      step();
      chk($sformatf("tmo wait%0d err", i), 32'(bus.err), 0);
    end
    step();
    chk("tmo err",  32'(bus.err), 32'(4'b0001));
    chk("tmo done", 32'(bus.done), 0);
    chk("tmo vld",  32'(bus.tx_valid), 0);
    drive(4'b0000, 16'h0007, 1'b0); step();
    chk("tmo err clr", 32'(bus.err), 0);
    // Ack on the expiry edge wins.
    drive(4'b0001, 16'h0007, 1'b0); step();
    for (int i = 0; i < 7; i++) step();
    bus.tx_ack = 1'b1; step();
    chk("tmo race done", 32'(bus.done), 32'(4'b0001));
    chk("tmo race err",  32'(bus.err), 0);
    drive(4'b0000, 16'h0000, 1'b0); step();
`endif

    // Randomized traffic against the model.
    rst = 1'b1; step(); rst = 1'b0;
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 3) == 0) bus.req = N'($urandom);
      bus.req_date = (N*W)'($urandom);
      bus.tx_ack   = ($urandom_range(0, 3) == 0);
      @(posedge sclk);
      model_edge(bus.req, bus.req_date, bus.tx_ack);
      @(negedge sclk);
      chk("rnd gnt",  32'(bus.gnt),  32'((m_owner >= 0) ? (N'(1) << m_owner) : N'(0)));
      chk("rnd done", 32'(bus.done), 32'(m_done));
      chk("rnd err",  32'(bus.err),  32'(m_err));
      chk("rnd vld",  32'(bus.tx_valid), 32'(m_owner >= 0));
      chk("rnd busy", 32'(bus.busy), 32'((m_owner >= 0) || m_cool));
      if (m_owner >= 0) chk("rnd txd", 32'(bus.tx_date), 32'(m_nib));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
